// File: rtl/sys_cmd_pkg.sv
// Shared definitions for the UART command decoder: host opcodes, operand
// register addresses and the decoder state encoding.
package sys_cmd_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned ADDR_OP_A = 32'd0;
    localparam int unsigned ADDR_OP_B = 32'd1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_ADDR  = 4'd1,
        ST_WR_DATA  = 4'd2,
        ST_RD_ADDR  = 4'd3,
        ST_RD_WAIT  = 4'd4,
        ST_PUSH_RD  = 4'd5,
        ST_ALU_A    = 4'd6,
        ST_ALU_B    = 4'd7,
        ST_ALU_FUN  = 4'd8,
        ST_ALU_WAIT = 4'd9,
        ST_PUSH_LO  = 4'd10,
        ST_PUSH_HI  = 4'd11
    } state_e;

endpackage

// File: rtl/sys_cmd_decoder.sv
// Host command responder: decodes the four-opcode byte protocol into register
// file / ALU strobes and pushes read data and ALU results into the TX FIFO.
module sys_cmd_decoder
    import sys_cmd_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int FUN_WIDTH     = 4
) (
    input  logic                     ref_clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    input  logic                     rx_valid,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    input  logic                     rd_data_valid,
    input  logic [ALU_OUT_WIDTH-1:0] alu_out,
    input  logic                     alu_out_valid,
    input  logic                     fifo_full,
    output logic                     wr_en,
    output logic                     rd_en,
    output logic [ADDR_WIDTH-1:0]    addr,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     alu_en,
    output logic [FUN_WIDTH-1:0]     alu_fun,
    output logic                     clk_gate_en,
    output logic                     fifo_wr_en,
    output logic [DATA_WIDTH-1:0]    fifo_wr_data
);

    state_e                   state_q, state_d;
    logic                     wr_en_q, wr_en_d;
    logic                     rd_en_q, rd_en_d;
    logic                     alu_en_q, alu_en_d;
    logic                     clk_gate_en_q, clk_gate_en_d;
    logic                     fifo_wr_en_q, fifo_wr_en_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic [FUN_WIDTH-1:0]     alu_fun_q, alu_fun_d;
    logic [DATA_WIDTH-1:0]    fifo_wr_data_q, fifo_wr_data_d;
    logic [DATA_WIDTH-1:0]    rd_cap_q, rd_cap_d;
    logic [ALU_OUT_WIDTH-1:0] alu_cap_q, alu_cap_d;

    // Next-state and next-output decode for the command FSM.
    always_comb begin
        state_d        = state_q;
        wr_en_d        = 1'b0;
        rd_en_d        = 1'b0;
        alu_en_d       = 1'b0;
        fifo_wr_en_d   = 1'b0;
        clk_gate_en_d  = clk_gate_en_q;
        addr_d         = addr_q;
        wr_data_d      = wr_data_q;
        alu_fun_d      = alu_fun_q;
        fifo_wr_data_d = fifo_wr_data_q;
        rd_cap_d       = rd_cap_q;
        alu_cap_d      = alu_cap_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_WR:      state_d = ST_WR_ADDR;
                        CMD_RD:      state_d = ST_RD_ADDR;
                        CMD_ALU_OP:  state_d = ST_ALU_A;
                        CMD_ALU_NOP: state_d = ST_ALU_FUN;
                        default:     state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_ADDR: begin
                if (rx_valid) begin
                    addr_d  = rx_data[ADDR_WIDTH-1:0];
                    state_d = ST_WR_DATA;
                end else begin
                    state_d = ST_WR_ADDR;
                end
            end
            ST_WR_DATA: begin
                if (rx_valid) begin
                    wr_data_d = rx_data;
                    wr_en_d   = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_RD_ADDR: begin
                if (rx_valid) begin
                    addr_d  = rx_data[ADDR_WIDTH-1:0];
                    rd_en_d = 1'b1;
                    state_d = ST_RD_WAIT;
                end else begin
                    state_d = ST_RD_ADDR;
                end
            end
            // The first push attempt is launched from the WAIT state so the
            // strobe appears one cycle after the valid; PUSH states retry.
            ST_RD_WAIT: begin
                if (rd_data_valid) begin
                    rd_cap_d       = rd_data;
                    fifo_wr_data_d = rd_data;
                    fifo_wr_en_d   = ~fifo_full;
                    state_d        = ST_PUSH_RD;
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_PUSH_RD: begin
                fifo_wr_data_d = rd_cap_q;
                if (fifo_wr_en_q) begin
                    state_d = ST_IDLE;
                end else if (!fifo_full) begin
                    fifo_wr_en_d = 1'b1;
                end else begin
                    fifo_wr_en_d = 1'b0;
                end
            end
            ST_ALU_A: begin
                if (rx_valid) begin
                    addr_d    = ADDR_WIDTH'(ADDR_OP_A);
                    wr_data_d = rx_data;
                    wr_en_d   = 1'b1;
                    state_d   = ST_ALU_B;
                end else begin
                    state_d = ST_ALU_A;
                end
            end
            ST_ALU_B: begin
                if (rx_valid) begin
                    addr_d    = ADDR_WIDTH'(ADDR_OP_B);
                    wr_data_d = rx_data;
                    wr_en_d   = 1'b1;
                    state_d   = ST_ALU_FUN;
                end else begin
                    state_d = ST_ALU_B;
                end
            end
            ST_ALU_FUN: begin
                if (rx_valid) begin
                    alu_fun_d     = rx_data[FUN_WIDTH-1:0];
                    alu_en_d      = 1'b1;
                    clk_gate_en_d = 1'b1;
                    state_d       = ST_ALU_WAIT;
                end else begin
                    state_d = ST_ALU_FUN;
                end
            end
            ST_ALU_WAIT: begin
                if (alu_out_valid) begin
                    alu_cap_d      = alu_out;
                    clk_gate_en_d  = 1'b0;
                    fifo_wr_data_d = alu_out[DATA_WIDTH-1:0];
                    fifo_wr_en_d   = ~fifo_full;
                    state_d        = ST_PUSH_LO;
                end else begin
                    state_d = ST_ALU_WAIT;
                end
            end
            ST_PUSH_LO: begin
                if (fifo_wr_en_q) begin
                    fifo_wr_data_d = alu_cap_q[DATA_WIDTH +: DATA_WIDTH];
                    fifo_wr_en_d   = ~fifo_full;
                    state_d        = ST_PUSH_HI;
                end else if (!fifo_full) begin
                    fifo_wr_data_d = alu_cap_q[DATA_WIDTH-1:0];
                    fifo_wr_en_d   = 1'b1;
                end else begin
                    fifo_wr_data_d = alu_cap_q[DATA_WIDTH-1:0];
                end
            end
            ST_PUSH_HI: begin
                fifo_wr_data_d = alu_cap_q[DATA_WIDTH +: DATA_WIDTH];
                if (fifo_wr_en_q) begin
                    state_d = ST_IDLE;
                end else if (!fifo_full) begin
                    fifo_wr_en_d = 1'b1;
                end else begin
                    fifo_wr_en_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            wr_en_q        <= 1'b0;
            rd_en_q        <= 1'b0;
            alu_en_q       <= 1'b0;
            clk_gate_en_q  <= 1'b0;
            fifo_wr_en_q   <= 1'b0;
            addr_q         <= '0;
            wr_data_q      <= '0;
            alu_fun_q      <= '0;
            fifo_wr_data_q <= '0;
            rd_cap_q       <= '0;
            alu_cap_q      <= '0;
        end else begin
            state_q        <= state_d;
            wr_en_q        <= wr_en_d;
            rd_en_q        <= rd_en_d;
            alu_en_q       <= alu_en_d;
            clk_gate_en_q  <= clk_gate_en_d;
            fifo_wr_en_q   <= fifo_wr_en_d;
            addr_q         <= addr_d;
            wr_data_q      <= wr_data_d;
            alu_fun_q      <= alu_fun_d;
            fifo_wr_data_q <= fifo_wr_data_d;
            rd_cap_q       <= rd_cap_d;
            alu_cap_q      <= alu_cap_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign rd_en        = rd_en_q;
    assign alu_en       = alu_en_q;
    assign clk_gate_en  = clk_gate_en_q;
    assign fifo_wr_en   = fifo_wr_en_q;
    assign addr         = addr_q;
    assign wr_data      = wr_data_q;
    assign alu_fun      = alu_fun_q;
    assign fifo_wr_data = fifo_wr_data_q;

endmodule

// File: doc/sys_cmd_decoder.md
# sys_cmd_decoder

Command responder for the UART-controlled ALU system, clocked in the `ref_clk` domain. It consumes synchronized RX bytes, decodes the four-command host protocol and issues register-file writes and reads and ALU operations. Read data and ALU results are pushed into the TX async FIFO for return to the host. It sits between the RX data synchronizer and the register file, ALU, clock gate and TX FIFO.

## Interface
Parameters:
- `DATA_WIDTH`, 8, byte width of RX, register file and FIFO data
- `ADDR_WIDTH`, 4, register-file address width
- `ALU_OUT_WIDTH`, 16, ALU result width; must equal 2×`DATA_WIDTH`
- `FUN_WIDTH`, 4, ALU function select width

Ports:
- `ref_clk` input, 1: the single clock; rising edge
- `rst` input, 1: asynchronous, active-low reset
- `rx_data` input, `DATA_WIDTH`: synchronized received byte
- `rx_valid` input, 1: one-cycle strobe qualifying `rx_data`
- `rd_data` input, `DATA_WIDTH`: register-file read data
- `rd_data_valid` input, 1: qualifies `rd_data`
- `alu_out` input, `ALU_OUT_WIDTH`: ALU result
- `alu_out_valid` input, 1: qualifies `alu_out`
- `fifo_full` input, 1: TX FIFO full
- `wr_en` output, 1: register-file write strobe
- `rd_en` output, 1: register-file read strobe
- `addr` output, `ADDR_WIDTH`: register-file address
- `wr_data` output, `DATA_WIDTH`: register-file write data
- `alu_en` output, 1: ALU start strobe
- `alu_fun` output, `FUN_WIDTH`: ALU function
- `clk_gate_en` output, 1: ALU clock-gate enable
- `fifo_wr_en` output, 1: TX FIFO push strobe
- `fifo_wr_data` output, `DATA_WIDTH`: TX FIFO push data

## Operation
- Opcodes:
  - `0xAA` register write: then ADDR byte, then DATA byte.
  - `0xBB` register read: then ADDR byte.
  - `0xCC` ALU with operands: then A byte, B byte, FUN byte.
  - `0xDD` ALU without operands: then FUN byte.
- ADDR uses `rx_data[ADDR_WIDTH-1:0]`; upper bits are ignored.
- FUN uses `rx_data[FUN_WIDTH-1:0]`.
- FSM states and transitions:
  - IDLE → WR_ADDR, RD_ADDR, ALU_A or ALU_FUN, according to the opcode.
  - WR_ADDR → WR_DATA. WR_DATA issues the write → IDLE.
  - RD_ADDR issues the read → RD_WAIT → PUSH_RD → IDLE.
  - ALU_A writes A to address 0 → ALU_B. ALU_B writes B to address 1 → ALU_FUN.
  - ALU_FUN issues `alu_en` → ALU_WAIT → PUSH_LO → PUSH_HI → IDLE.
- Unknown opcode in IDLE: byte dropped, FSM stays in IDLE.
- `rx_valid` while in RD_WAIT, ALU_WAIT or any PUSH state: byte dropped.
- The address byte is latched; `addr` holds the latched value until the next command.
- Read response is one byte, `rd_data`.
- ALU response is two bytes: `alu_out[7:0]` first, then `alu_out[15:8]`.
- `rd_data` and `alu_out` are captured into internal registers on their valid strobes.

## Timing
- Reset values: every output is 0. `addr`, `wr_data` and `alu_fun` are 0. FSM is in IDLE.
- Reset asserted mid-command: immediate return to IDLE, all strobes drop the same instant, partial command discarded.
- `wr_en`, `rd_en` and `alu_en` are single-cycle pulses, asserted the cycle after the `rx_valid` of the final byte. `addr` and `wr_data` are valid in that same cycle.
- Operand writes: `wr_en` pulses one cycle after the A `rx_valid` with `addr`=0, and one cycle after the B `rx_valid` with `addr`=1.
- `clk_gate_en` rises with the FUN-byte `alu_en` cycle, or one cycle earlier (registered), and stays high through ALU_WAIT. It falls the cycle after `alu_out_valid`.
- PUSH state: `fifo_wr_en`=1 for exactly one cycle, and only when `fifo_full`=0. While full, the FSM holds in the PUSH state with data stable and retries each cycle.
- Latencies with FIFO not full:
  - Read: `rd_data_valid` → `fifo_wr_en` is 1 cycle.
  - ALU: `alu_out_valid` → low-byte push is 1 cycle; high-byte push follows on the next cycle.
- `rd_data_valid` or `alu_out_valid` outside the matching WAIT state: ignored.

## Structure
- Shared package `sys_cmd_pkg`:
  - opcode constants `CMD_WR`=8'hAA, `CMD_RD`=8'hBB, `CMD_ALU_OP`=8'hCC, `CMD_ALU_NOP`=8'hDD
  - state encoding
  - operand addresses `ADDR_OP_A`=0, `ADDR_OP_B`=1
- Single module. No sub-module: the FSM, capture registers and push logic together fit in roughly 250 lines.

## Test plan
- Write: bytes AA, 08, DD → one `wr_en` pulse with `addr`=8, `wr_data`=DD; no FIFO push.
- Read: bytes BB, 08, then `rd_data_valid` with DD → `rd_en` pulse with `addr`=8, then one `fifo_wr_en` with data DD.
- ALU with operands: bytes CC, 08, 02, 01, then `alu_out`=0x0006 → writes 08@0 and 02@1, `alu_en` with `alu_fun`=1, pushes 06 then 00, and `clk_gate_en` low afterwards.
- ALU without operands: bytes DD, 0D, then `alu_out`=0x0004 → no `wr_en`, `alu_fun`=D, pushes 04 then 00.
- Backpressure and filtering: `fifo_full`=1 for 5 cycles during PUSH_LO → no push while full, push 1 cycle after full deasserts, data unchanged. Byte 0x55 in IDLE → no strobes, stays IDLE.
- Reset mid-command: `rst` low after AA, 08 → outputs 0. After release, DD alone produces no `wr_en`.
